// File: rtl/io_input_conditioner_if.sv
// Conditioned switch/button bundle between io_input_conditioner (master) and the LSU (slave).
// The sticky press flags exist only when IO_COND_STICKY_EN is defined.
interface io_input_conditioner_if #(
  parameter int SW_W  = 32,
  parameter int BTN_W = 4
);
  logic [SW_W-1:0]  sw_o;
  logic [BTN_W-1:0] btn_o;
  logic [BTN_W-1:0] btn_press_o;
  logic [BTN_W-1:0] btn_release_o;
`ifdef IO_COND_STICKY_EN
  logic [BTN_W-1:0] btn_clr_i;
  logic [BTN_W-1:0] btn_sticky_o;
`endif

  modport master (
    output sw_o, btn_o, btn_press_o, btn_release_o
`ifdef IO_COND_STICKY_EN
    , input btn_clr_i
    , output btn_sticky_o
`endif
  );

  modport slave (
    input sw_o, btn_o, btn_press_o, btn_release_o
`ifdef IO_COND_STICKY_EN
    , output btn_clr_i
    , input btn_sticky_o
`endif
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronises, debounces and edge-detects raw board switches and buttons.
// Optional sticky press flags are enabled by defining IO_COND_STICKY_EN.
module io_input_conditioner #(
  parameter int SW_W            = 32,
  parameter int BTN_W           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [SW_W-1:0]        sw_raw_i,
  input  logic [BTN_W-1:0]       btn_raw_i,
  io_input_conditioner_if.master cond
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CH_W  = SW_W + BTN_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [BTN_W-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};

  logic [SW_W-1:0]  sw_s1_r, sw_s2_r;
  logic [BTN_W-1:0] btn_s1_r, btn_s2_r;
  logic [BTN_W-1:0] btn_y_s;
  logic [CH_W-1:0]  y_s;
  logic [CH_W-1:0]  stable_r, stable_nxt_s;
  logic [CNT_W-1:0] cnt_r [CH_W];
  logic [CNT_W-1:0] cnt_nxt_s [CH_W];
  logic [BTN_W-1:0] press_r, release_r;
  logic [BTN_W-1:0] btn_stable_s, btn_nxt_s;

  // Two-flop synchronisers; buttons reset to their idle level so no press appears at release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_s1_r  <= {SW_W{1'b0}};
      sw_s2_r  <= {SW_W{1'b0}};
      btn_s1_r <= BTN_IDLE;
      btn_s2_r <= BTN_IDLE;
    end else begin
      sw_s1_r  <= sw_raw_i;
      sw_s2_r  <= sw_s1_r;
      btn_s1_r <= btn_raw_i;
      btn_s2_r <= btn_s1_r;
    end
  end

  assign btn_y_s = (BTN_ACTIVE_LOW != 0) ? ~btn_s2_r : btn_s2_r;
  assign y_s     = {btn_y_s, sw_s2_r};

  // Per-channel debounce: any cycle agreeing with the accepted level restarts the count.
  always_comb begin
    stable_nxt_s = stable_r;
    for (int i = 0; i < CH_W; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
      if (y_s[i] == stable_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = y_s[i];
        cnt_nxt_s[i]    = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  assign btn_stable_s = stable_r[CH_W-1:SW_W];
  assign btn_nxt_s    = stable_nxt_s[CH_W-1:SW_W];

  // Accepted levels, counters and edge pulses; pulses line up with the btn_o transition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_r  <= {CH_W{1'b0}};
      press_r   <= {BTN_W{1'b0}};
      release_r <= {BTN_W{1'b0}};
      for (int i = 0; i < CH_W; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      stable_r  <= stable_nxt_s;
      press_r   <= btn_nxt_s & ~btn_stable_s;
      release_r <= ~btn_nxt_s & btn_stable_s;
      for (int i = 0; i < CH_W; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign cond.sw_o          = stable_r[SW_W-1:0];
  assign cond.btn_o         = btn_stable_s;
  assign cond.btn_press_o   = press_r;
  assign cond.btn_release_o = release_r;

`ifdef IO_COND_STICKY_EN
  logic [BTN_W-1:0] sticky_r;

  // Latched press flags; a press pulse outranks a clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_r <= {BTN_W{1'b0}};
    end else begin
      sticky_r <= press_r | (sticky_r & ~cond.btn_clr_i);
    end
  end

  assign cond.btn_sticky_o = sticky_r;
`endif

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Conditions raw board switches and push-buttons before they reach the LSU input buffer.
- Synchronises every raw bit into clk_i with a 2-flop synchroniser.
- Debounces each bit per channel and normalises button polarity to active-high.
- Generates one-cycle press/release pulses per button.
- sw_o drives the LSU io_sw_i input; btn_o drives the LSU io_btn_i input.

Parameters:
SW_W, 32, number of switch channels
BTN_W, 4, number of button channels
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a change (1 ms at 50 MHz); legal range >= 1
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
sw_raw_i  in  SW_W  raw switch pins, asynchronous
btn_raw_i  in  BTN_W  raw button pins, asynchronous
sw_o  out  SW_W  debounced switch levels
btn_o  out  BTN_W  debounced button levels, 1 = pressed
btn_press_o  out  BTN_W  1-cycle pulse on each bit's btn_o 0->1
btn_release_o  out  BTN_W  1-cycle pulse on each bit's btn_o 1->0
btn_clr_i  in  BTN_W  sticky clear mask (present only with IO_COND_STICKY_EN)
btn_sticky_o  out  BTN_W  latched press flags (present only with IO_COND_STICKY_EN)

Behaviour:
Clock and reset
- One clock: clk_i. Reset is asynchronous, active-high: rst_i.
- Reset values:
  - Switch synchroniser flops: 0.
  - Button synchroniser flops: idle level (1 if BTN_ACTIVE_LOW, else 0). No press is seen at reset release.
  - All counters: 0.
  - sw_o = 0, btn_o = 0, btn_press_o = 0, btn_release_o = 0, btn_sticky_o = 0.

Datapath
- Per bit: raw -> s1 -> s2. Buttons are then inverted if BTN_ACTIVE_LOW, giving the synced level y.
- Each channel has a stable register (drives sw_o/btn_o) and a counter cnt.
- Each cycle, per channel:
  - y == stable: cnt <= 0.
  - y != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - y != stable and cnt == DEBOUNCE_CYCLES-1: stable <= y, cnt <= 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles (any cycle with y == stable) restarts the count; stable does not change.
- Latency: raw held constant -> output changes DEBOUNCE_CYCLES+2 cycles later (2 for sync, DEBOUNCE_CYCLES for debounce).
- DEBOUNCE_CYCLES = 1: output updates on the first edge the mismatch is seen (latency 3).
- Pulses: btn_press_o[i] = 1 for exactly the one cycle after btn_o[i] rises; btn_release_o[i] likewise on fall. Both are registered.
- Channels are fully independent. Simultaneous changes on several bits each follow their own counter.
- Outputs are registered; no combinational path from any raw input to any output.
- Reset asserted mid-count: counters clear immediately and outputs return to reset values. After release, debouncing restarts from scratch.
- Switches high at reset release: sw_o rises after DEBOUNCE_CYCLES+2 cycles. This is normal behaviour.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Optional Feature:
IO_COND_STICKY_EN
- Defined:
  - Adds btn_clr_i and btn_sticky_o.
  - btn_sticky_o[i] sets on the cycle btn_press_o[i] is high and holds until btn_clr_i[i] = 1 at a rising edge.
  - Set wins over a simultaneous clear.
  - btn_sticky_o resets to 0.
- Undefined:
  - Both ports and all sticky logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset release with btn_raw_i = 4'hF, sw_raw_i = 0, DEBOUNCE_CYCLES = 4 -> btn_o = 0, btn_press_o never pulses, sw_o = 0 for the whole run.
2. sw_raw_i goes 0 -> 32'hA5A5_0001 and is held -> sw_o = 32'hA5A5_0001 exactly 6 cycles later and not before.
3. btn_raw_i[2] pulled low for 3 cycles, high for 1, then low and held (N = 4) -> no change during the glitch; btn_o[2] = 1 six cycles after the final fall; btn_press_o = 4'b0100 for one cycle.
4. btn_raw_i[0] and btn_raw_i[3] released on the same edge after a debounced press -> btn_release_o = 4'b1001 for one cycle, 6 cycles later.
5. rst_i asserted asynchronously between clock edges, 2 cycles into a switch debounce -> all outputs 0 immediately; after release the change completes 6 cycles after the next edge, not earlier.
6. With IO_COND_STICKY_EN: press btn[1] -> btn_sticky_o = 4'b0010 and held; btn_clr_i = 4'b0010 on the same cycle as a second press pulse -> stays 1; clear on a later cycle -> 0.
